// File: rtl/interval_timer_if.sv
// Controller-side bundle for interval_timer: start/programming requests
// and countdown status.
interface interval_timer_if #(
    parameter int VAL_W = 4
);
    logic             start_timer;
    logic [1:0]       interval;
    logic             prog_sync;
    logic [1:0]       time_param_sel;
    logic [VAL_W-1:0] time_value;
    logic             expired;
    logic             busy;
    logic [VAL_W:0]   remaining;

    modport master (
        output start_timer, interval, prog_sync,
        output time_param_sel, time_value,
        input  expired, busy, remaining
    );

    modport slave (
        input  start_timer, interval, prog_sync,
        input  time_param_sel, time_value,
        output expired, busy, remaining
    );
endinterface

// File: rtl/interval_timer.sv
// Programmable one-second countdown timer for the traffic-light controller.
// Define EXPIRED_LEVEL_EN to hold expired high until the next start/prog.
module interval_timer #(
    parameter int CLK_DIV  = 1000,
    parameter int VAL_W    = 4,
    parameter int DEF_BASE = 6,
    parameter int DEF_EXT  = 3,
    parameter int DEF_YEL  = 2
) (
    input logic             clk,
    input logic             reset,
    interval_timer_if.slave tif
);
    localparam int PS_W = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [VAL_W-1:0] BASE0   = VAL_W'(DEF_BASE);
    localparam logic [VAL_W-1:0] EXT0    = VAL_W'(DEF_EXT);
    localparam logic [VAL_W-1:0] YEL0    = VAL_W'(DEF_YEL);
    localparam logic [VAL_W:0]   ONE     = (VAL_W+1)'(1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state, state_n;
    logic [PS_W-1:0]  presc, presc_n;
    logic [VAL_W:0]   rem, rem_n, dur;
    logic [VAL_W-1:0] t_base, t_ext, t_yel;
    logic [VAL_W-1:0] base_n, ext_n, yel_n;
    logic             start_d, start_edge, tick;
    logic             exp_q, exp_n;

    assign start_edge = tif.start_timer & ~start_d;
    assign tick       = (state == COUNT) && (presc == PS_LAST);

    always_comb begin
        dur = '0;
        unique case (tif.interval)
            2'b00: dur = {1'b0, t_base};
            2'b01: dur = {1'b0, t_ext};
            2'b10: dur = {1'b0, t_yel};
            2'b11: dur = {1'b0, t_base} + {1'b0, t_ext};
        endcase
        // A zero duration still has to last one full tick.
        if (dur == '0)
            dur = ONE;
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        rem_n   = rem;
        base_n  = t_base;
        ext_n   = t_ext;
        yel_n   = t_yel;
`ifdef EXPIRED_LEVEL_EN
        exp_n   = exp_q;
`else
        exp_n   = 1'b0;
`endif
        if (tif.prog_sync) begin
            unique case (tif.time_param_sel)
                2'b00: base_n = tif.time_value;
                2'b01: ext_n  = tif.time_value;
                2'b10: yel_n  = tif.time_value;
                2'b11: begin
                    base_n = BASE0;
                    ext_n  = EXT0;
                    yel_n  = YEL0;
                end
            endcase
            state_n = IDLE;
            presc_n = '0;
            rem_n   = '0;
            exp_n   = 1'b0;
        end else if (start_edge) begin
            state_n = COUNT;
            presc_n = '0;
            rem_n   = dur;
            exp_n   = 1'b0;
        end else if (state == COUNT) begin
            if (tick) begin
                presc_n = '0;
                rem_n   = rem - ONE;
                if (rem == ONE) begin
                    state_n = IDLE;
                    exp_n   = 1'b1;
                end
            end else begin
                presc_n = presc + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            rem     <= '0;
            exp_q   <= 1'b0;
            start_d <= 1'b0;
            t_base  <= BASE0;
            t_ext   <= EXT0;
            t_yel   <= YEL0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            rem     <= rem_n;
            exp_q   <= exp_n;
            start_d <= tif.start_timer;
            t_base  <= base_n;
            t_ext   <= ext_n;
            t_yel   <= yel_n;
        end
    end

    assign tif.expired   = exp_q;
    assign tif.busy      = (state == COUNT);
    assign tif.remaining = rem;
endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer with CLK_DIV=4 and default durations.
// Expected expiry cycles are queued by stimulus and checked by a monitor.
module tb_interval_timer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    interval_timer_if #(.VAL_W(4)) tif ();

    interval_timer #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_exp  = 0;
    int   exp_q[$];
    logic exp_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising expired is matched against the queued cycle.
    always @(negedge clk) begin
        if (tif.expired && !exp_prev) begin
            n_exp++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL expiry_unexpected: got cycle %0d, required none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc != e) begin
                    errors++;
                    $display("FAIL expiry_cycle: got %0d, required %0d", cyc, e);
                end
            end
        end
`ifndef EXPIRED_LEVEL_EN
        if (exp_prev) begin
            checks++;
            if (tif.expired) begin
                errors++;
                $display("FAIL pulse_width: got expired=1, required 0 at cycle %0d", cyc);
            end
        end
`endif
        exp_prev = tif.expired;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Start request; d is the hand-computed effective duration in seconds.
    task automatic start(input logic [1:0] iv, input int d, input bit push);
        @(negedge clk);
        tif.interval    = iv;
        tif.start_timer = 1'b1;
        if (push) exp_q.push_back(cyc + 1 + d * 4);
        @(negedge clk);
        tif.start_timer = 1'b0;
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        @(negedge clk);
        tif.prog_sync      = 1'b1;
        tif.time_param_sel = sel;
        tif.time_value     = val;
        @(negedge clk);
        tif.prog_sync      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tif.busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d, required 0/0",
                     name, tif.busy, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        reset              = 1'b1;
        tif.start_timer    = 1'b0;
        tif.interval       = 2'b00;
        tif.prog_sync      = 1'b0;
        tif.time_param_sel = 2'b00;
        tif.time_value     = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_expired", int'(tif.expired), 0);
        check("rst_busy", int'(tif.busy), 0);
        check("rst_remaining", int'(tif.remaining), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Base count with remaining stepping down every 4 cycles
        start(2'b00, 6, 1'b1);
        check("base_busy", int'(tif.busy), 1);
        check("base_rem0", int'(tif.remaining), 6);
        for (int k = 1; k <= 6; k++) begin
            repeat (4) @(negedge clk);
            check("base_rem", int'(tif.remaining), 6 - k);
        end
        check("base_busy_end", int'(tif.busy), 0);
        wait_idle("base");

        // Programmed base, then restore defaults
        prog(2'b00, 4'd9);
        start(2'b00, 9, 1'b1);
        wait_idle("prog_base9");
        prog(2'b11, 4'd15);
        start(2'b00, 6, 1'b1);
        wait_idle("restore");

        // Interval codes, zero duration
        start(2'b11, 9, 1'b1);
        wait_idle("sum");
        start(2'b10, 2, 1'b1);
        wait_idle("yel");
        prog(2'b10, 4'd0);
        start(2'b10, 1, 1'b1);
        wait_idle("yel_zero");
        prog(2'b11, 4'd0);

        // Restart at edge 10 with interval 01
        start(2'b00, 6, 1'b0);
        repeat (9) @(negedge clk);
        tif.interval    = 2'b01;
        tif.start_timer = 1'b1;
        exp_q.push_back(cyc + 1 + 12);
        @(negedge clk);
        tif.start_timer = 1'b0;
        check("restart_rem", int'(tif.remaining), 3);
        wait_idle("restart");

        // Start edge on the terminal tick wins
        start(2'b10, 2, 1'b0);
        repeat (7) @(negedge clk);
        tif.interval    = 2'b00;
        tif.start_timer = 1'b1;
        exp_q.push_back(cyc + 1 + 24);
        @(negedge clk);
        tif.start_timer = 1'b0;
        check("term_restart_busy", int'(tif.busy), 1);
        wait_idle("term_restart");

        // Mid-count programming aborts
        n0 = n_exp;
        start(2'b00, 6, 1'b0);
        repeat (5) @(negedge clk);
        prog(2'b01, 4'd3);
        check("abort_busy", int'(tif.busy), 0);
        check("abort_rem", int'(tif.remaining), 0);
        repeat (40) @(negedge clk);
        check("abort_no_expiry", n_exp, n0);

        // prog_sync together with a start edge drops the start
        @(negedge clk);
        tif.prog_sync      = 1'b1;
        tif.time_param_sel = 2'b11;
        tif.start_timer    = 1'b1;
        tif.interval       = 2'b00;
        @(negedge clk);
        tif.prog_sync = 1'b0;
        check("prog_start_busy", int'(tif.busy), 0);
        repeat (3) @(negedge clk);
        check("prog_start_noretrig", int'(tif.busy), 0);
        tif.start_timer = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-count reset restores defaults
        n0 = n_exp;
        prog(2'b00, 4'd9);
        start(2'b00, 9, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_expired", int'(tif.expired), 0);
        check("mrst_busy", int'(tif.busy), 0);
        check("mrst_remaining", int'(tif.remaining), 0);
        @(negedge clk);
        reset = 1'b0;
        check("mrst_no_expiry", n_exp, n0);
        start(2'b00, 6, 1'b1);
        wait_idle("mrst_default");

`ifdef EXPIRED_LEVEL_EN
        start(2'b10, 2, 1'b1);
        wait_idle("level");
        repeat (5) @(negedge clk);
        check("level_held", int'(tif.expired), 1);
        @(negedge clk);
        tif.interval    = 2'b00;
        tif.start_timer = 1'b1;
        exp_q.push_back(cyc + 1 + 24);
        @(negedge clk);
        tif.start_timer = 1'b0;
        check("level_clear", int'(tif.expired), 0);
        check("level_busy", int'(tif.busy), 1);
        wait_idle("level_next");
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable countdown timer that serves the traffic-light controller's timer requests. The controller raises `start_timer` with a 2-bit `interval` code; this block loads the matching programmed duration in seconds, counts it down on a one-second tick derived from `clk`, and signals `expired`. It also holds the base, extended, and yellow durations, which are rewritten through the synchronized programming strobe `prog_sync`.

## Interface
- `CLK_DIV`, default 1000: clk cycles per one-second tick; must be ≥2.
- `VAL_W`, default 4: width of each programmed duration, in seconds.
- `DEF_BASE`, default 6: reset value of t_base.
- `DEF_EXT`, default 3: reset value of t_ext.
- `DEF_YEL`, default 2: reset value of t_yel.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start_timer`  in  1  start request; the rising edge is detected internally.
- `interval`  in  2  duration select: 00 = t_base, 01 = t_ext, 10 = t_yel, 11 = t_base+t_ext.
- `prog_sync`  in  1  one-cycle programming strobe, already synchronized.
- `time_param_sel`  in  2  programming target: 00 = base, 01 = ext, 10 = yel, 11 = restore all defaults.
- `time_value`  in  VAL_W  value written on `prog_sync`.
- `expired`  out  1  countdown complete.
- `busy`  out  1  countdown in progress.
- `remaining`  out  VAL_W+1  seconds left in the current count.

## Operation
- Reset values:
  - `expired`=0, `busy`=0, `remaining`=0.
  - Prescaler=0, `start_timer` delay flop=0.
  - t_base=DEF_BASE, t_ext=DEF_EXT, t_yel=DEF_YEL.
- Start edge: `start_timer`=1 this cycle and the delay flop=0.
- State machine has two states, IDLE and COUNT.
  - IDLE → COUNT on a start edge. `remaining` loads the selected duration, the prescaler clears, `busy`=1.
  - COUNT: the prescaler counts 0..CLK_DIV-1. At CLK_DIV-1 a tick fires and `remaining` decrements.
  - COUNT → IDLE on the tick that takes `remaining` from 1 to 0. That same edge asserts `expired`; `busy`=0.
  - A start edge in COUNT restarts: reload, clear the prescaler, stay in COUNT. Any pending expiry is discarded.
- Arithmetic:
  - Interval code 11 loads t_base+t_ext, zero-extended to VAL_W+1 bits, with no overflow.
  - A selected duration of 0 loads as 1, so a count always lasts at least one tick.
- Programming, on a cycle with `prog_sync`=1:
  - Selects 00/01/10 write `time_value` to the chosen parameter. Select 11 restores all three defaults and ignores `time_value`.
  - Any active count aborts: go to IDLE, `busy`=0, `remaining`=0, no `expired`.
  - A new value affects only counts started after the write.
- Simultaneous events:
  - `prog_sync` together with a start edge: programming wins and the start edge is dropped. The delay flop still updates, so that start does not re-trigger later.
  - A start edge on the terminal-tick cycle: the restart wins and `expired` does not assert.
- Reset mid-count returns the block immediately to the reset values, with no `expired`.
- The `interval` input is sampled only on the start edge.

## Timing
- Edge 0 is the clk edge that first samples `start_timer`=1.
- `busy` and `remaining` are valid after edge 0.
- `expired` rises after edge D·CLK_DIV, where D is the effective duration. Its width depends on the configuration below.
- `remaining` equals D−k after k ticks. It reads 0 while IDLE.
- Programming takes effect at the edge sampling `prog_sync`. A start edge on the very next cycle uses the new value.
- `expired` is fully registered and glitch-free. The controller consumes it edge-triggered.

## Configuration
- `EXPIRED_LEVEL_EN` defined:
  - `expired` is a level, held high from the terminal tick until the next start edge, `prog_sync`, or `reset`.
  - On a start edge it clears at that same edge.
- `EXPIRED_LEVEL_EN` not defined (default): `expired` is a single-cycle pulse, high for exactly one clk after the terminal tick.

## Test plan
All scenarios use CLK_DIV=4 and default durations.
- After reset, raise `start_timer` with `interval`=00 → `busy`=1 from edge 0; `expired` pulses once, high after edge 24; `remaining` steps 6,5,…,0 every 4 cycles.
- Pulse `prog_sync` with sel=00, value=9, then start with `interval`=00 → `expired` after edge 36. Then sel=11, start `interval`=00 → `expired` after edge 24.
- Start with `interval`=11 → `expired` after edge 36 (6+3 s); `interval`=10 → `expired` after edge 8. Program t_yel=0, start `interval`=10 → `expired` after edge 4.
- Start `interval`=00, then at edge 10 drop and re-raise `start_timer` with `interval`=01 → no `expired` at 24; `expired` occurs 12 cycles after the restart edge.
- Mid-count `prog_sync` (any select) → `busy`=0, `remaining`=0, no `expired`. Mid-count `reset` → all outputs 0 and parameters at defaults.
- With `EXPIRED_LEVEL_EN` defined, start `interval`=10 → `expired` is high from edge 8 and stays high until the next start edge, where it drops; a new count proceeds.
